// File: rtl/mem_sched_pkg.sv
// Shared configuration for the memory request scheduler: default widths,
// port/requester relation check and the read-tag record.
package mem_sched_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDR_WIDTH_DEF = 4;
    localparam int NUM_PORTS_DEF  = 4;
    localparam int NUM_REQ_DEF    = 8;

    function automatic int tag_id_width(input int num_req);
        return (num_req <= 1) ? 1 : $clog2(num_req);
    endfunction

    localparam int TAG_ID_W = tag_id_width(NUM_REQ_DEF);

    // One tag per memory port: which requester a read issued on that port belongs to.
    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

    function automatic bit cfg_ok(input int num_ports, input int num_req);
        return (num_ports >= 1) && (num_req >= num_ports) &&
               (tag_id_width(num_req) <= TAG_ID_W);
    endfunction

endpackage

// File: rtl/rr_port_alloc.sv
// Rotating requester scan that packs eligible requests onto free memory ports,
// deferring any write whose address was already granted to an earlier write.
module rr_port_alloc
    import mem_sched_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int NUM_PORTS  = NUM_PORTS_DEF,
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int ID_W       = tag_id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [ID_W-1:0]               rr_ptr,
    output logic [NUM_REQ-1:0]            grant,
    output logic [NUM_PORTS-1:0]          port_used,
    output logic [NUM_PORTS*ID_W-1:0]     port_id,
    output logic [ID_W-1:0]               last_win,
    output logic                          any_grant
);

    localparam int NUM_ADDR = 1 << ADDR_WIDTH;

    // Scan requesters from rr_ptr, granting onto the lowest free port.
    always_comb begin
        logic [NUM_ADDR-1:0]   wr_taken;
        logic [ADDR_WIDTH-1:0] addr;
        logic                  elig;
        int                    idx;
        int                    nport;
        grant     = '0;
        port_used = '0;
        port_id   = '0;
        last_win  = rr_ptr;
        any_grant = 1'b0;
        wr_taken  = '0;
        addr      = '0;
        elig      = 1'b0;
        idx       = 0;
        nport     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx  = (int'(rr_ptr) + k >= NUM_REQ) ? int'(rr_ptr) + k - NUM_REQ
                                                   : int'(rr_ptr) + k;
            addr = req_addr[idx*ADDR_WIDTH +: ADDR_WIDTH];
            elig = req_valid[idx] && (nport < NUM_PORTS) &&
                   !(req_we[idx] && wr_taken[addr]);
            if (elig) begin
                grant[idx]                   = 1'b1;
                port_used[nport]             = 1'b1;
                port_id[nport*ID_W +: ID_W]  = ID_W'(idx);
                wr_taken[addr]               = wr_taken[addr] | req_we[idx];
                last_win                     = ID_W'(idx);
                any_grant                    = 1'b1;
                nport                        = nport + 1;
            end else begin
                grant[idx] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mem_req_sched.sv
// Multi-requester scheduler in front of multi_port_memory: round-robin port
// packing, write-collision deferral and tagged one-cycle read-response routing.
module mem_req_sched
    import mem_sched_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int NUM_PORTS  = NUM_PORTS_DEF,
    parameter int NUM_REQ    = NUM_REQ_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0]              req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [NUM_REQ*DATA_WIDTH-1:0]   rsp_rdata,
    output logic [NUM_PORTS-1:0]            mem_we,
    output logic [NUM_PORTS*ADDR_WIDTH-1:0] mem_addr,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] mem_wdata,
    output logic [NUM_PORTS-1:0]            mem_re,
    output logic [NUM_PORTS*ADDR_WIDTH-1:0] mem_raddr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] mem_rdata
);

    localparam int ID_W = tag_id_width(NUM_REQ);

    if (!cfg_ok(NUM_PORTS, NUM_REQ)) begin : g_bad_cfg
        $error("mem_req_sched: NUM_REQ must be >= NUM_PORTS and fit the tag id");
    end

    logic [ID_W-1:0]           rr_ptr_q, rr_ptr_d;
    tag_t [NUM_PORTS-1:0]      tag_q, tag_d;
    logic [NUM_REQ-1:0]        alloc_valid_s;
    logic [NUM_REQ-1:0]        grant_s;
    logic [NUM_PORTS-1:0]      port_used_s;
    logic [NUM_PORTS*ID_W-1:0] port_id_s;
    logic [ID_W-1:0]           last_win_s;
    logic                      any_grant_s;

    // Nothing may be accepted or issued while reset is held.
    assign alloc_valid_s = req_valid & ~{NUM_REQ{rst}};
    assign req_ready     = grant_s;

    rr_port_alloc #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_PORTS  (NUM_PORTS),
        .NUM_REQ    (NUM_REQ),
        .ID_W       (ID_W)
    ) u_alloc (
        .req_valid  (alloc_valid_s),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .rr_ptr     (rr_ptr_q),
        .grant      (grant_s),
        .port_used  (port_used_s),
        .port_id    (port_id_s),
        .last_win   (last_win_s),
        .any_grant  (any_grant_s)
    );

    // Drive each memory port from its assigned requester and build the next tags.
    always_comb begin
        logic [ID_W-1:0] sel;
        mem_we    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_re    = '0;
        mem_raddr = '0;
        tag_d     = '0;
        sel       = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            sel = port_id_s[p*ID_W +: ID_W];
            if (port_used_s[p]) begin
                if (req_we[sel]) begin
                    mem_we[p]                              = 1'b1;
                    mem_addr[p*ADDR_WIDTH +: ADDR_WIDTH]   = req_addr[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
                    mem_wdata[p*DATA_WIDTH +: DATA_WIDTH]  = req_wdata[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
                end else begin
                    mem_re[p]                              = 1'b1;
                    mem_raddr[p*ADDR_WIDTH +: ADDR_WIDTH]  = req_addr[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
                    tag_d[p].valid                         = 1'b1;
                    tag_d[p].id                            = TAG_ID_W'(sel);
                end
            end else begin
                tag_d[p] = '0;
            end
        end
    end

    // Pointer moves just past the last winner so every winner yields next cycle.
    always_comb begin
        if (any_grant_s) begin
            rr_ptr_d = (int'(last_win_s) == NUM_REQ - 1) ? '0 : last_win_s + ID_W'(1);
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Tag ids are unique per cycle, so OR-merging the ports never collides.
    always_comb begin
        rsp_valid = '0;
        rsp_rdata = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            rsp_valid[tag_q[p].id] = rsp_valid[tag_q[p].id] | tag_q[p].valid;
            rsp_rdata[int'(tag_q[p].id)*DATA_WIDTH +: DATA_WIDTH] =
                rsp_rdata[int'(tag_q[p].id)*DATA_WIDTH +: DATA_WIDTH] |
                (mem_rdata[p*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{tag_q[p].valid}});
        end
    end

    // Scheduler state; reset drops any in-flight read tags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
            tag_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            tag_q    <= tag_d;
        end
    end

endmodule

// File: tb/tb_mem_req_sched.sv
// Bench for mem_req_sched: behavioural memory, queue-based scheduling model
// checked every cycle, plus directed literal expectations.
module tb_mem_req_sched;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int NP = 4;
    localparam int NR = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_we    = '0;
    logic [NR*AW-1:0]  req_addr  = '0;
    logic [NR*DW-1:0]  req_wdata = '0;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     rsp_valid;
    logic [NR*DW-1:0]  rsp_rdata;
    logic [NP-1:0]     mem_we;
    logic [NP*AW-1:0]  mem_addr;
    logic [NP*DW-1:0]  mem_wdata;
    logic [NP-1:0]     mem_re;
    logic [NP*AW-1:0]  mem_raddr;
    logic [NP*DW-1:0]  env_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0]    env_mem   [16];
    logic [DW-1:0]    model_mem [16];
    logic [NR-1:0]    pend_v = '0;
    logic [NR*DW-1:0] pend_d = '0;
    int               m_ptr  = 0;

    bit stats_on = 1'b0;
    int g_cnt [NR];
    int w_cur [NR];
    int w_max = 0;

    always #5 clk = ~clk;

    mem_req_sched #(
        .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .NUM_PORTS (NP), .NUM_REQ (NR)
    ) dut (
        .clk (clk), .rst (rst),
        .req_valid (req_valid), .req_we (req_we), .req_addr (req_addr), .req_wdata (req_wdata),
        .req_ready (req_ready), .rsp_valid (rsp_valid), .rsp_rdata (rsp_rdata),
        .mem_we (mem_we), .mem_addr (mem_addr), .mem_wdata (mem_wdata),
        .mem_re (mem_re), .mem_raddr (mem_raddr), .mem_rdata (env_rdata)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural memory: registered read, write at the same edge (old data on read).
    initial begin
        for (int i = 0; i < 16; i++) env_mem[i] = 8'(16 + i);
        forever begin
            @(posedge clk);
            for (int p = 0; p < NP; p++) begin
                if (mem_re[p]) env_rdata[p*DW +: DW] <= env_mem[mem_raddr[p*AW +: AW]];
                if (mem_we[p]) env_mem[mem_addr[p*AW +: AW]] <= mem_wdata[p*DW +: DW];
            end
        end
    end

    task automatic model_cycle();
        int            gnt [$];
        logic [AW-1:0] wr_addrs [$];
        logic [NR-1:0]    e_ready = '0;
        logic [NP-1:0]    e_we = '0, e_re = '0;
        logic [NP*AW-1:0] e_addr = '0, e_raddr = '0;
        logic [NP*DW-1:0] e_wdata = '0;
        logic [NR-1:0]    e_rv = rst ? '0 : pend_v;
        logic [NR*DW-1:0] e_rd = rst ? '0 : pend_d;
        if (!rst) begin
            for (int k = 0; k < NR; k++) begin
                int r;
                logic [AW-1:0] a;
                bit clash;
                r = (m_ptr + k) % NR;
                a = req_addr[r*AW +: AW];
                clash = 1'b0;
                foreach (wr_addrs[i]) if (wr_addrs[i] == a) clash = 1'b1;
                if (gnt.size() < NP && req_valid[r] && !(req_we[r] && clash)) begin
                    gnt.push_back(r);
                    if (req_we[r]) wr_addrs.push_back(a);
                end
            end
        end
        foreach (gnt[p]) begin
            int r;
            r = gnt[p];
            e_ready[r] = 1'b1;
            if (req_we[r]) begin
                e_we[p] = 1'b1;
                e_addr[p*AW +: AW]  = req_addr[r*AW +: AW];
                e_wdata[p*DW +: DW] = req_wdata[r*DW +: DW];
            end else begin
                e_re[p] = 1'b1;
                e_raddr[p*AW +: AW] = req_addr[r*AW +: AW];
            end
        end
        check("req_ready", req_ready, e_ready);
        check("mem_we", mem_we, e_we);
        check("mem_addr", mem_addr, e_addr);
        check("mem_wdata", mem_wdata, e_wdata);
        check("mem_re", mem_re, e_re);
        check("mem_raddr", mem_raddr, e_raddr);
        check("rsp_valid", rsp_valid, e_rv);
        check("rsp_rdata", rsp_rdata, e_rd);
        pend_v = '0;
        pend_d = '0;
        if (rst) begin
            m_ptr = 0;
        end else begin
            foreach (gnt[p]) if (!req_we[gnt[p]]) begin
                pend_v[gnt[p]] = 1'b1;
                pend_d[gnt[p]*DW +: DW] = model_mem[req_addr[gnt[p]*AW +: AW]];
            end
            foreach (gnt[p]) if (req_we[gnt[p]])
                model_mem[req_addr[gnt[p]*AW +: AW]] = req_wdata[gnt[p]*DW +: DW];
            if (gnt.size() > 0) m_ptr = (gnt[gnt.size()-1] + 1) % NR;
        end
        if (stats_on) begin
            for (int r = 0; r < NR; r++) begin
                if (req_ready[r]) begin
                    g_cnt[r]++;
                    if (w_cur[r] + 1 > w_max) w_max = w_cur[r] + 1;
                    w_cur[r] = 0;
                end else if (req_valid[r]) begin
                    w_cur[r]++;
                end
            end
        end
    endtask

    // Compare process: model and DUT checked at every falling edge.
    initial begin
        for (int i = 0; i < 16; i++) model_mem[i] = 8'(16 + i);
        forever begin
            @(negedge clk);
            model_cycle();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input bit v, input bit we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[r] = v;
        req_we[r] = we;
        req_addr[r*AW +: AW] = a;
        req_wdata[r*DW +: DW] = d;
    endtask

    task automatic all_reads(input logic [NR-1:0] v);
        for (int r = 0; r < NR; r++) set_req(r, v[r], 1'b0, 4'(r), 8'h00);
    endtask

    initial begin
        all_reads(8'hFF);
        step(); step();
        @(negedge clk);
        check("ready_in_reset", req_ready, 8'h00);
        check("re_in_reset", mem_re, 4'h0);
        step(); rst = 1'b0;
        @(negedge clk);
        check("t1_ready0", req_ready, 8'h0F);
        check("t1_raddr0", mem_raddr, 16'h3210);
        step(); all_reads(8'hF0);
        @(negedge clk);
        check("t1_ready1", req_ready, 8'hF0);
        check("t1_raddr1", mem_raddr, 16'h7654);
        check("t1_rspv0", rsp_valid, 8'h0F);
        check("t1_rd0", rsp_rdata[7:0], 8'h10);
        check("t1_rd3", rsp_rdata[31:24], 8'h13);
        step(); all_reads(8'h00);
        @(negedge clk);
        check("t1_rspv1", rsp_valid, 8'hF0);
        check("t1_rd7", rsp_rdata[63:56], 8'h17);

        step();
        set_req(1, 1'b1, 1'b1, 4'h3, 8'hAA);
        set_req(5, 1'b1, 1'b1, 4'h3, 8'h55);
        @(negedge clk);
        check("t2_ready0", req_ready, 8'h02);
        check("t2_we0", mem_we, 4'b0001);
        check("t2_addr0", mem_addr[3:0], 4'h3);
        check("t2_wdata0", mem_wdata[7:0], 8'hAA);
        step(); set_req(1, 1'b0, 1'b0, 4'h0, 8'h00);
        @(negedge clk);
        check("t2_ready1", req_ready, 8'h20);
        step(); set_req(5, 1'b0, 1'b0, 4'h0, 8'h00); set_req(0, 1'b1, 1'b0, 4'h3, 8'h00);
        @(negedge clk);
        check("t2_ready2", req_ready, 8'h01);
        step(); set_req(0, 1'b0, 1'b0, 4'h0, 8'h00);
        @(negedge clk);
        check("t2_rspv", rsp_valid, 8'h01);
        check("t2_rd", rsp_rdata[7:0], 8'h55);

        step();
        set_req(2, 1'b1, 1'b1, 4'h9, 8'h7C);
        set_req(3, 1'b1, 1'b0, 4'h9, 8'h00);
        @(negedge clk);
        check("t3_ready", req_ready, 8'h0C);
        check("t3_we", mem_we, 4'b0001);
        check("t3_re", mem_re, 4'b0010);
        check("t3_raddr", mem_raddr[7:4], 4'h9);
        step(); set_req(2, 1'b0, 1'b0, 4'h0, 8'h00); set_req(3, 1'b0, 1'b0, 4'h0, 8'h00);
        set_req(4, 1'b1, 1'b0, 4'h9, 8'h00);
        @(negedge clk);
        check("t3_old", rsp_rdata[31:24], 8'h19);
        step(); set_req(4, 1'b0, 1'b0, 4'h0, 8'h00);
        @(negedge clk);
        check("t3_new", rsp_rdata[39:32], 8'h7C);

        step();
        for (int r = 0; r < NR; r++) begin
            g_cnt[r] = 0;
            w_cur[r] = 0;
            set_req(r, 1'b1, (r % 2) == 0, 4'(r), 8'(8'hC0 + r));
        end
        w_max = 0;
        stats_on = 1'b1;
        repeat (10) step();
        stats_on = 1'b0;
        all_reads(8'h00);
        for (int r = 0; r < NR; r++) check("t4_fair", (g_cnt[r] >= 4 && g_cnt[r] <= 6), 1'b1);
        check("t4_wait", (w_max <= 3), 1'b1);
        step();

        all_reads(8'h0F);
        @(negedge clk);
        check("t5_ready", req_ready, 8'h0F);
        step(); rst = 1'b1; all_reads(8'hFF);
        @(negedge clk);
        check("t5_rsp_drop", rsp_valid, 8'h00);
        check("t5_ready_rst", req_ready, 8'h00);
        step(); rst = 1'b0;
        @(negedge clk);
        check("t5_ptr0", req_ready, 8'h0F);
        check("t5_no_replay", rsp_valid, 8'h00);
        step(); all_reads(8'h00);
        @(negedge clk);
        check("t5_rsp", rsp_valid, 8'h0F);

        step(); set_req(6, 1'b1, 1'b0, 4'h5, 8'h00);
        @(negedge clk);
        check("t6_ready", req_ready, 8'h40);
        check("t6_re", mem_re, 4'b0001);
        check("t6_raddr", mem_raddr, 16'h0005);
        check("t6_we", mem_we, 4'h0);
        check("t6_addr", mem_addr, 16'h0000);
        check("t6_wdata", mem_wdata, 32'h0);
        step(); all_reads(8'hFF);
        @(negedge clk);
        check("t6_ptr7", req_ready, 8'h87);
        check("t6_rd6", rsp_rdata[55:48], 8'h15);
        step(); all_reads(8'h00);
        step(); step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
